sh_break_ctrl: RTL and testbench

Parametrised user break controller for the SH core. It holds NCH break channels, each with an address/mask, a data/mask and a bus-cycle condition. It watches the internal CPU/DMA bus monitor port, latches per-channel match flags, supports sequential (chained) breaks and a channel-0 pass counter, and raises a level break IRQ. It sits on IBUS alongside the other on-chip peripherals and is register-compatible in style with them.

---
 rtl/sh_break_ctrl_pkg.sv | 54 +++++
 rtl/sh_break_match.sv | 34 +++
 rtl/sh_break_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_sh_break_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sh_break_ctrl_pkg.sv
// Shared types and register constants for the SH user break controller.
package sh_break_ctrl_pkg;

    // Break bus-cycle condition register (lives in bus bits [31:16]).
    typedef struct packed {
        logic [7:0] rsv_h;
        logic [1:0] cp;     // 01 CPU, 10 DMA, 11 both
        logic [1:0] id;     // 01 fetch, 10 data, 11 both
        logic [1:0] rw;     // 01 read, 10 write, 11 both
        logic       rsv_l;
        logic       de;     // data compare enable
    } UBC_BBR_t;

    // Break control register (lives in bus bits [31:16] of the global word).
    typedef struct packed {
        logic       ie;
        logic       seq;
        logic [9:0] rsv;
        logic [3:0] cmf;
    } UBC_BRCR_t;

    localparam logic [15:0] BBR_INIT   = '0;
    localparam logic [15:0] BBR_WMASK  = 16'h00FD;
    localparam logic [15:0] BBR_RMASK  = 16'h00FD;
    localparam logic [15:0] BRCR_INIT  = '0;
    localparam logic [15:0] BRCR_WMASK = 16'hC00F;
    localparam logic [15:0] BRCR_RMASK = 16'hC00F;
    localparam logic [15:0] BCNT_INIT  = '0;
    localparam logic [15:0] BCNT_WMASK = 16'hFFFF;
    localparam logic [15:0] BCNT_RMASK = 16'hFFFF;

    localparam int unsigned CH_STRIDE = 32;

    // Byte-lane gated, write-masked merge of a 32-bit register.
    function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  ba,
                                               input logic [31:0] wmask);
        logic [31:0] m;
        m = {{8{ba[3]}}, {8{ba[2]}}, {8{ba[1]}}, {8{ba[0]}}} & wmask;
        return (old_v & ~m) | (wdata & m);
    endfunction

    // Same merge for a 16-bit register mapped to bus bits [31:16].
    function automatic logic [15:0] lane_merge_hi(input logic [15:0] old_v,
                                                  input logic [31:0] wdata,
                                                  input logic [3:0]  ba,
                                                  input logic [15:0] wmask);
        logic [15:0] m;
        m = {{8{ba[3]}}, {8{ba[2]}}} & wmask;
        return (old_v & ~m) | (wdata[31:16] & m);
    endfunction

endpackage

// File: rtl/sh_break_match.sv
// One break channel's combinational hit detector.
module sh_break_match
    import sh_break_ctrl_pkg::*;
(
    input  logic [31:0] bar_i,
    input  logic [31:0] bamr_i,
    input  UBC_BBR_t    bbr_i,
    input  logic [31:0] bdr_i,
    input  logic [31:0] bdmr_i,
    input  logic        mon_valid_i,
    input  logic [31:0] mon_a_i,
    input  logic [31:0] mon_d_i,
    input  logic        mon_wr_i,
    input  logic        mon_if_i,
    input  logic        mon_dma_i,
    output logic        hit_o
);

    logic cp_ok, id_ok, rw_ok, addr_ok, data_ok;
    logic unused_bbr;

    assign unused_bbr = ^{bbr_i.rsv_h, bbr_i.rsv_l};

    // Cycle-type qualifiers, masked address compare, optional data compare (never on fetches)
    always_comb begin
        cp_ok   = mon_dma_i ? bbr_i.cp[1] : bbr_i.cp[0];
        id_ok   = mon_if_i  ? bbr_i.id[0] : bbr_i.id[1];
        rw_ok   = mon_wr_i  ? bbr_i.rw[1] : bbr_i.rw[0];
        addr_ok = ((mon_a_i ^ bar_i) & ~bamr_i) == '0;
        data_ok = !bbr_i.de || mon_if_i || (((mon_d_i ^ bdr_i) & ~bdmr_i) == '0);
        hit_o   = mon_valid_i & cp_ok & id_ok & rw_ok & addr_ok & data_ok;
    end

endmodule

// File: rtl/sh_break_ctrl.sv
// User break controller: channel register file, 2-stage match pipeline,
// channel-0 pass counter, match flags and IBUS read path.
module sh_break_ctrl
    import sh_break_ctrl_pkg::*;
#(
    parameter int unsigned NCH      = 2,
    parameter logic [31:0] REG_BASE = 32'hFFFFFF40
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        CE_R,
    input  logic        CE_F,
    input  logic        RES_N,
    input  logic [31:0] IBUS_A,
    input  logic [31:0] IBUS_DI,
    output logic [31:0] IBUS_DO,
    input  logic [3:0]  IBUS_BA,
    input  logic        IBUS_WE,
    input  logic        IBUS_REQ,
    output logic        IBUS_BUSY,
    output logic        IBUS_ACT,
    input  logic        MON_VALID,
    input  logic [31:0] MON_A,
    input  logic [31:0] MON_D,
    input  logic        MON_WR,
    input  logic        MON_IF,
    input  logic        MON_DMA,
    output logic        IRQ
);

    localparam logic [31:0] GLB_OFF   = 32'(NCH * CH_STRIDE);
    localparam logic [31:0] WIN_BYTES = 32'(NCH * CH_STRIDE + 8);

    logic [31:0] bar_q  [NCH];
    logic [31:0] bamr_q [NCH];
    UBC_BBR_t    bbr_q  [NCH];
    logic [31:0] bdr_q  [NCH];
    logic [31:0] bdmr_q [NCH];
    logic        ie_q, seq_q;
    logic [NCH-1:0] cmf_q, cmf_d, flag_set;
    logic [15:0] bcnt_q, bcnt_d;
    logic [NCH-1:0] hit, hit_q;
    logic [31:0] reg_do_q, rdata;

    logic [31:0] off;
    logic        reg_sel, ch_area, glb_sel, wr_en, rd_en;
    logic [1:0]  ch_idx;
    logic [2:0]  word;
    UBC_BRCR_t   brcr_rd;

    // Register window decode
    always_comb begin
        off     = IBUS_A - REG_BASE;
        reg_sel = off < WIN_BYTES;
        ch_area = off < GLB_OFF;
        ch_idx  = off[6:5];
        word    = off[4:2];
        glb_sel = reg_sel && !ch_area && (word == 3'd0);
        wr_en   = reg_sel && IBUS_REQ && IBUS_WE;
        rd_en   = reg_sel && IBUS_REQ && !IBUS_WE;
    end

    assign IBUS_ACT  = reg_sel;
    assign IBUS_BUSY = 1'b0;
    assign IBUS_DO   = reg_sel ? reg_do_q : '0;
    assign IRQ       = ie_q & (|cmf_q);

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        sh_break_match u_match (
            .bar_i       (bar_q[g]),
            .bamr_i      (bamr_q[g]),
            .bbr_i       (bbr_q[g]),
            .bdr_i       (bdr_q[g]),
            .bdmr_i      (bdmr_q[g]),
            .mon_valid_i (MON_VALID),
            .mon_a_i     (MON_A),
            .mon_d_i     (MON_D),
            .mon_wr_i    (MON_WR),
            .mon_if_i    (MON_IF),
            .mon_dma_i   (MON_DMA),
            .hit_o       (hit[g])
        );
    end

    // Channel configuration registers and IE/SEQ control bits
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int unsigned n = 0; n < NCH; n++) begin
                bar_q[n]  <= '0;
                bamr_q[n] <= '0;
                bbr_q[n]  <= BBR_INIT;
                bdr_q[n]  <= '0;
                bdmr_q[n] <= '0;
            end
            ie_q  <= 1'b0;
            seq_q <= 1'b0;
        end else if (CE_R) begin
            if (!RES_N) begin
                for (int unsigned n = 0; n < NCH; n++) begin
                    bar_q[n]  <= '0;
                    bamr_q[n] <= '0;
                    bbr_q[n]  <= BBR_INIT;
                    bdr_q[n]  <= '0;
                    bdmr_q[n] <= '0;
                end
                ie_q  <= 1'b0;
                seq_q <= 1'b0;
            end else if (wr_en) begin
                for (int unsigned n = 0; n < NCH; n++) begin
                    if (ch_area && ch_idx == 2'(n)) begin
                        case (word)
                            3'd0: bar_q[n]  <= lane_merge(bar_q[n], IBUS_DI, IBUS_BA, '1);
                            3'd1: bamr_q[n] <= lane_merge(bamr_q[n], IBUS_DI, IBUS_BA, '1);
                            3'd2: bbr_q[n]  <= lane_merge_hi(bbr_q[n], IBUS_DI, IBUS_BA, BBR_WMASK);
                            3'd3: bdr_q[n]  <= lane_merge(bdr_q[n], IBUS_DI, IBUS_BA, '1);
                            3'd4: bdmr_q[n] <= lane_merge(bdmr_q[n], IBUS_DI, IBUS_BA, '1);
                            default: ;
                        endcase
                    end
                end
                if (glb_sel && IBUS_BA[3]) begin
                    ie_q  <= IBUS_DI[31] & BRCR_WMASK[15];
                    seq_q <= IBUS_DI[30] & BRCR_WMASK[14];
                end
            end
        end
    end

    // Stage 2: flag set / pass counter; sets override a same-cycle clear, BCNT write overrides decrement
    always_comb begin
        flag_set = '0;
        bcnt_d   = bcnt_q;
        if (hit_q[0]) begin
            if (bcnt_q <= 16'd1) flag_set[0] = 1'b1;
            if (bcnt_q != '0)    bcnt_d = bcnt_q - 16'd1;
        end
        for (int unsigned n = 1; n < NCH; n++) begin
            if (hit_q[n] && (!seq_q || cmf_q[n-1])) flag_set[n] = 1'b1;
        end
        cmf_d = cmf_q;
        if (wr_en && glb_sel) begin
            if (IBUS_BA[2]) cmf_d = cmf_q & IBUS_DI[16 +: NCH];
            if (IBUS_BA[1]) bcnt_d[15:8] = IBUS_DI[15:8] & BCNT_WMASK[15:8];
            if (IBUS_BA[0]) bcnt_d[7:0]  = IBUS_DI[7:0]  & BCNT_WMASK[7:0];
        end
        cmf_d = cmf_d | flag_set;
    end

    // Stage 1 hit register plus flag/counter state
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            hit_q  <= '0;
            cmf_q  <= '0;
            bcnt_q <= BCNT_INIT;
        end else if (CE_R) begin
            if (!RES_N) begin
                hit_q  <= '0;
                cmf_q  <= '0;
                bcnt_q <= BCNT_INIT;
            end else begin
                hit_q  <= hit;
                cmf_q  <= cmf_d;
                bcnt_q <= bcnt_d;
            end
        end
    end

    // Read data mux; unmapped offsets read 0
    always_comb begin
        rdata       = '0;
        brcr_rd     = BRCR_INIT;
        brcr_rd.ie  = ie_q;
        brcr_rd.seq = seq_q;
        brcr_rd.cmf = 4'(cmf_q);
        for (int unsigned n = 0; n < NCH; n++) begin
            if (ch_area && ch_idx == 2'(n)) begin
                case (word)
                    3'd0: rdata = bar_q[n];
                    3'd1: rdata = bamr_q[n];
                    3'd2: rdata = {bbr_q[n] & BBR_RMASK, 16'h0000};
                    3'd3: rdata = bdr_q[n];
                    3'd4: rdata = bdmr_q[n];
                    default: rdata = '0;
                endcase
            end
        end
        if (glb_sel) rdata = {brcr_rd & BRCR_RMASK, bcnt_q & BCNT_RMASK};
    end

    // Read data latch on the falling-phase enable
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            reg_do_q <= '0;
        end else if (CE_R && !RES_N) begin
            reg_do_q <= '0;
        end else if (CE_F && rd_en) begin
            reg_do_q <= rdata;
        end
    end

endmodule

// File: tb/tb_sh_break_ctrl.sv
// Self-checking bench for sh_break_ctrl: directed test-plan steps followed
// by a randomized phase, all checked against a behavioural register model.
module tb_sh_break_ctrl;

    localparam int          NCH = 2;
    localparam logic [31:0] B   = 32'hFFFFFF40;
    localparam logic [31:0] GLB = B + 32'h40;

    logic        CLK = 1'b0, RST_N = 1'b0, CE_R = 1'b0, CE_F = 1'b0, RES_N = 1'b1;
    logic [31:0] IBUS_A = '0, IBUS_DI = '0, IBUS_DO;
    logic [3:0]  IBUS_BA = '0;
    logic        IBUS_WE = 1'b0, IBUS_REQ = 1'b0, IBUS_BUSY, IBUS_ACT;
    logic        MON_VALID = 1'b0, MON_WR = 1'b0, MON_IF = 1'b0, MON_DMA = 1'b0;
    logic [31:0] MON_A = '0, MON_D = '0;
    logic        IRQ;

    sh_break_ctrl #(.NCH(NCH), .REG_BASE(B)) dut (
        .CLK(CLK), .RST_N(RST_N), .CE_R(CE_R), .CE_F(CE_F), .RES_N(RES_N),
        .IBUS_A(IBUS_A), .IBUS_DI(IBUS_DI), .IBUS_DO(IBUS_DO), .IBUS_BA(IBUS_BA),
        .IBUS_WE(IBUS_WE), .IBUS_REQ(IBUS_REQ), .IBUS_BUSY(IBUS_BUSY), .IBUS_ACT(IBUS_ACT),
        .MON_VALID(MON_VALID), .MON_A(MON_A), .MON_D(MON_D), .MON_WR(MON_WR),
        .MON_IF(MON_IF), .MON_DMA(MON_DMA), .IRQ(IRQ)
    );

    always #5 CLK = ~CLK;

    int unsigned checks = 0, passed = 0;

    // Model: register window as words, control bits, flags, counter, in-flight hits
    logic [31:0] m_reg [18];
    logic        m_ie, m_seq;
    logic [1:0]  m_cmf, m_pend;
    logic [15:0] m_bcnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 18; i++) m_reg[i] = '0;
        m_ie = 1'b0; m_seq = 1'b0; m_cmf = '0; m_pend = '0; m_bcnt = '0;
    endtask

    function automatic logic model_hit(input int n);
        logic [31:0] bar, bamr, bdr, bdmr, w2;
        logic [7:0]  bbr;
        logic [1:0]  want_cp, want_id, want_rw;
        bar = m_reg[n*8]; bamr = m_reg[n*8+1]; w2 = m_reg[n*8+2];
        bdr = m_reg[n*8+3]; bdmr = m_reg[n*8+4];
        bbr = w2[23:16];
        want_cp = MON_DMA ? 2'b10 : 2'b01;
        want_id = MON_IF  ? 2'b01 : 2'b10;
        want_rw = MON_WR  ? 2'b10 : 2'b01;
        return MON_VALID && ((bbr[7:6] & want_cp) != 0) && ((bbr[5:4] & want_id) != 0)
            && ((bbr[3:2] & want_rw) != 0) && (((MON_A ^ bar) & ~bamr) == 0)
            && (!bbr[0] || MON_IF || (((MON_D ^ bdr) & ~bdmr) == 0));
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] addr);
        logic [31:0] off;
        int unsigned w;
        off = addr - B;
        w   = off >> 2;
        if (off >= 32'h48) return '0;
        if (w == 16) return {m_ie, m_seq, 12'b0, m_cmf, m_bcnt};
        if (w < 16 && (w % 8) <= 4) return m_reg[w];
        return '0;
    endfunction

    // One rising-phase cycle: advance the model from the driven inputs, clock, check IRQ
    task automatic tick_r();
        logic [1:0]  nh, sets, ncmf;
        logic [15:0] nb;
        logic [31:0] off, bm, msk;
        int unsigned w;
        if (!RES_N) begin
            model_reset();
        end else begin
            for (int n = 0; n < NCH; n++) nh[n] = model_hit(n);
            sets = '0;
            nb   = m_bcnt;
            if (m_pend[0]) begin
                if (m_bcnt <= 1) sets[0] = 1'b1;
                if (m_bcnt != 0) nb = m_bcnt - 16'd1;
            end
            for (int n = 1; n < NCH; n++)
                if (m_pend[n] && (!m_seq || m_cmf[n-1])) sets[n] = 1'b1;
            ncmf = m_cmf;
            off  = IBUS_A - B;
            w    = off >> 2;
            bm   = {{8{IBUS_BA[3]}}, {8{IBUS_BA[2]}}, {8{IBUS_BA[1]}}, {8{IBUS_BA[0]}}};
            if (IBUS_REQ && IBUS_WE && off < 32'h48) begin
                if (w == 16) begin
                    if (IBUS_BA[3]) begin m_ie = IBUS_DI[31]; m_seq = IBUS_DI[30]; end
                    if (IBUS_BA[2]) ncmf = ncmf & IBUS_DI[17:16];
                    if (IBUS_BA[1]) nb[15:8] = IBUS_DI[15:8];
                    if (IBUS_BA[0]) nb[7:0]  = IBUS_DI[7:0];
                end else if (w < 16 && (w % 8) <= 4) begin
                    msk = bm & (((w % 8) == 2) ? 32'h00FD0000 : 32'hFFFFFFFF);
                    m_reg[w] = (m_reg[w] & ~msk) | (IBUS_DI & msk);
                end
            end
            m_cmf  = ncmf | sets;
            m_bcnt = nb;
            m_pend = nh;
        end
        CE_R = 1'b1;
        @(posedge CLK); #1;
        CE_R = 1'b0; IBUS_REQ = 1'b0; IBUS_WE = 1'b0; MON_VALID = 1'b0; RES_N = 1'b1;
        chk("irq", 32'(IRQ), 32'(m_ie & (|m_cmf)));
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] ba);
        IBUS_A = a; IBUS_DI = d; IBUS_BA = ba; IBUS_WE = 1'b1; IBUS_REQ = 1'b1;
        tick_r();
    endtask

    task automatic mon(input logic [31:0] a, input logic [31:0] d,
                       input logic w, input logic f, input logic dm);
        MON_VALID = 1'b1; MON_A = a; MON_D = d; MON_WR = w; MON_IF = f; MON_DMA = dm;
        tick_r();
    endtask

    task automatic rd(input logic [31:0] a, input string tag);
        IBUS_A = a; IBUS_REQ = 1'b1; IBUS_WE = 1'b0; CE_F = 1'b1;
        @(posedge CLK); #1;
        CE_F = 1'b0; IBUS_REQ = 1'b0;
        chk(tag, IBUS_DO, model_read(a));
        chk("act", 32'(IBUS_ACT), 32'((a - B) < 32'h48));
    endtask

    task automatic rdc(input logic [31:0] a, input logic [31:0] exp, input string tag);
        rd(a, tag);
        chk({tag, "_const"}, IBUS_DO, exp);
    endtask

    // A cycle with no enables: a write and a hitting bus cycle must both be ignored
    task automatic hold_cyc();
        IBUS_A = GLB; IBUS_DI = '0; IBUS_BA = 4'hF; IBUS_WE = 1'b1; IBUS_REQ = 1'b1;
        MON_VALID = 1'b1; MON_A = m_reg[0]; MON_IF = 1'b1; MON_WR = 1'b0; MON_DMA = 1'b0;
        @(posedge CLK); #1;
        IBUS_WE = 1'b0; IBUS_REQ = 1'b0; MON_VALID = 1'b0;
        chk("hold_irq", 32'(IRQ), 32'(m_ie & (|m_cmf)));
    endtask

    initial begin
        logic [31:0] a, d;
        int unsigned ch, r;
        model_reset();
        #12;
        chk("rst_irq", 32'(IRQ), 32'd0);
        chk("rst_do", IBUS_DO, 32'd0);
        chk("rst_busy", 32'(IBUS_BUSY), 32'd0);
        chk("rst_act", 32'(IBUS_ACT), 32'd0);
        @(negedge CLK); RST_N = 1'b1;
        @(posedge CLK); #1;
        rdc(B, 32'd0, "rst_bar0");
        rdc(GLB, 32'd0, "rst_glb");

        // Fetch break on channel 0, two-cycle latency to IRQ
        wr(B + 32'h00, 32'h06001000, 4'hF);
        wr(B + 32'h04, 32'h0, 4'hF);
        wr(B + 32'h08, 32'hFFFF0000, 4'hF);
        rdc(B + 32'h08, 32'h00FD0000, "bbr_wmask");
        wr(B + 32'h08, 32'h00550000, 4'hF);
        wr(GLB, 32'h80000000, 4'b1100);
        mon(32'h06001000, 32'h0, 1'b0, 1'b1, 1'b0);
        chk("tp1_irq_stage1", 32'(IRQ), 32'd0);
        tick_r();
        chk("tp1_irq", 32'(IRQ), 32'd1);
        rdc(GLB, 32'h80010000, "tp1_brcr");
        wr(GLB, 32'h80000000, 4'b1100);
        mon(32'h06001004, 32'h0, 1'b0, 1'b1, 1'b0);
        tick_r();
        rdc(GLB, 32'h80000000, "tp1_nohit");

        // DMA data write with masked address and data compare
        wr(B + 32'h04, 32'h000000FF, 4'hF);
        wr(B + 32'h08, 32'h00A90000, 4'b1100);
        wr(B + 32'h0C, 32'h00001234, 4'hF);
        wr(B + 32'h10, 32'hFFFF0000, 4'hF);
        mon(32'h060010FC, 32'hABCD1234, 1'b1, 1'b0, 1'b1);
        tick_r();
        rdc(GLB, 32'h80010000, "tp2_hit");
        wr(GLB, 32'h80000000, 4'b1100);
        mon(32'h060010FC, 32'h00001235, 1'b1, 1'b0, 1'b1);
        tick_r();
        rdc(GLB, 32'h80000000, "tp2_nohit");

        // Channel-0 pass counter, including back-to-back hits
        wr(B + 32'h04, 32'h0, 4'hF);
        wr(B + 32'h08, 32'h00550000, 4'b1100);
        wr(GLB, 32'h00000003, 4'b0011);
        mon(32'h06001000, 32'h0, 1'b0, 1'b1, 1'b0);
        tick_r();
        rdc(GLB, 32'h80000002, "cnt_hit1");
        mon(32'h06001000, 32'h0, 1'b0, 1'b1, 1'b0);
        mon(32'h06001000, 32'h0, 1'b0, 1'b1, 1'b0);
        tick_r();
        rdc(GLB, 32'h80010000, "cnt_hit3");
        mon(32'h06001000, 32'h0, 1'b0, 1'b1, 1'b0);
        tick_r();
        rdc(GLB, 32'h80010000, "cnt_hit4");

        // Sequential break chain
        wr(B + 32'h20, 32'h06002000, 4'hF);
        wr(B + 32'h24, 32'h0, 4'hF);
        wr(B + 32'h28, 32'h00550000, 4'hF);
        wr(GLB, 32'hC0000000, 4'b1100);
        mon(32'h06002000, 32'h0, 1'b0, 1'b1, 1'b0);
        tick_r();
        rdc(GLB, 32'hC0000000, "seq_ch1_first");
        mon(32'h06001000, 32'h0, 1'b0, 1'b1, 1'b0);
        tick_r();
        mon(32'h06002000, 32'h0, 1'b0, 1'b1, 1'b0);
        tick_r();
        rdc(GLB, 32'hC0030000, "seq_chain");
        wr(GLB, 32'hC0000000, 4'b1100);
        wr(B + 32'h20, 32'h06001000, 4'hF);
        mon(32'h06001000, 32'h0, 1'b0, 1'b1, 1'b0);
        tick_r();
        rdc(GLB, 32'hC0010000, "seq_same_cycle");

        // Set beats clear; writing 1 to CMF keeps flags; BCNT write beats decrement
        mon(32'h06001000, 32'h0, 1'b0, 1'b1, 1'b0);
        wr(GLB, 32'hC0000000, 4'b1100);
        rdc(GLB, 32'hC0030000, "set_beats_clear");
        wr(GLB, 32'hC0030000, 4'b1100);
        rdc(GLB, 32'hC0030000, "cmf_write1");
        wr(GLB, 32'h00000005, 4'b0011);
        mon(32'h06001000, 32'h0, 1'b0, 1'b1, 1'b0);
        wr(GLB, 32'h00000009, 4'b0011);
        rdc(GLB, 32'hC0030009, "bcnt_write_wins");
        hold_cyc();
        rdc(GLB, 32'hC0030009, "hold_state");

        // Soft reset discards a pending stage-1 hit
        mon(32'h06001000, 32'h0, 1'b0, 1'b1, 1'b0);
        RES_N = 1'b0;
        tick_r();
        chk("res_irq", 32'(IRQ), 32'd0);
        tick_r();
        rdc(GLB, 32'h0, "res_glb");
        rdc(B, 32'h0, "res_bar0");
        rdc(B + 32'h14, 32'h0, "unmapped_ch");
        rdc(B + 32'h44, 32'h0, "unmapped_glb");
        rdc(B + 32'h48, 32'h0, "outside");

        // Randomized phase
        for (int n = 0; n < NCH; n++) begin
            wr(B + 32'(n*32),      32'h06000000 | ($urandom & 32'h300), 4'hF);
            wr(B + 32'(n*32) + 4,  $urandom & 32'h0F, 4'hF);
            wr(B + 32'(n*32) + 8,  ($urandom & 32'hFF) << 16, 4'hF);
            wr(B + 32'(n*32) + 12, $urandom & 32'hFFFF, 4'hF);
            wr(B + 32'(n*32) + 16, $urandom & 32'hFFFF00FF, 4'hF);
        end
        wr(GLB, 32'h80000000 | ($urandom & 32'h40000000) | $urandom_range(0, 3), 4'hF);
        for (int it = 0; it < 300; it++) begin
            r  = $urandom_range(0, 7);
            ch = $urandom_range(0, NCH - 1);
            if (r <= 4) begin
                a = m_reg[ch*8] ^ (($urandom_range(0, 3) == 0) ? ($urandom & 32'h10F) : 32'h0);
                d = m_reg[ch*8+3] ^ (($urandom_range(0, 1) == 0) ? $urandom : 32'h0);
                mon(a, d, 1'($urandom), 1'($urandom), 1'($urandom));
            end else if (r == 5) begin
                wr(GLB, ($urandom & 32'hC0030000) | $urandom_range(0, 3), 4'($urandom));
            end else if (r == 6) begin
                rd(B + (($urandom % 18) << 2), "rand_rd");
            end else begin
                hold_cyc();
            end
            if (it % 16 == 15) rd(GLB, "rand_glb");
        end
        rd(GLB, "final_glb");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
